// File: rtl/rnd_sample_hold_pkg.sv
// Shared definitions for the rnd noise modules: default widths, mode encoding, FSM states.
package rnd_sample_hold_pkg;

    localparam int unsigned RndWidth    = 8;
    localparam int unsigned RndDivWidth = 16;

    typedef enum logic {
        ModeStep = 1'b0,
        ModeSlew = 1'b1
    } rnd_mode_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } rnd_state_e;

endpackage

// File: rtl/tick_div.sv
// Rate divider: while enabled, counts 0..period and emits a tick on the edge that wraps to 0.
module tick_div #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] period,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    // Using >= rather than == means a period lowered below cnt wraps on the very next edge.
    always_comb begin
        tick  = enable && (cnt_q >= period);
        cnt_d = '0;
        if (enable && !tick) begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rnd_sample_hold.sv
// Sample-and-hold noise source: captures rnd_in at a programmable rate, either stepping
// straight to the new value or slewing toward it by a power-of-two fraction each cycle.
module rnd_sample_hold
    import rnd_sample_hold_pkg::*;
#(
    parameter int unsigned WIDTH     = RndWidth,
    parameter int unsigned DIV_WIDTH = RndDivWidth
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     rnd_in,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic                 mode,
    input  logic [2:0]           shift,
    output logic [WIDTH-1:0]     sample_out,
    output logic                 sample_valid,
    output logic [WIDTH-1:0]     target
);

    rnd_state_e state_q, state_d;
    rnd_mode_e  mode_sel;
    logic       run;
    logic       tick;

    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             valid_q, valid_d;

    logic signed [WIDTH:0] slew_diff;
    logic signed [WIDTH:0] slew_step;
    logic [WIDTH-1:0]      slew_next;

    assign run      = (state_q == StRun);
    assign mode_sel = rnd_mode_e'(mode);

    // Fed by the registered state, not enable, so a tick still lands on the edge enable falls.
    tick_div #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick_div (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (run),
        .period (period),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable)  state_d = StRun;
            StRun:  if (!enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The step always lies between 0 and the difference, so the sum stays inside 0..2^WIDTH-1.
    always_comb begin
        slew_diff = $signed({1'b0, target_q}) - $signed({1'b0, sample_q});
        slew_step = slew_diff >>> shift;
        slew_next = sample_q + WIDTH'(slew_step);
    end

    always_comb begin
        sample_d = sample_q;
        target_d = target_q;
        valid_d  = 1'b0;
        if (run) begin
            if (tick) begin
                target_d = rnd_in;
                valid_d  = 1'b1;
            end
            if (mode_sel == ModeSlew) begin
                sample_d = slew_next;
            end else if (tick) begin
                sample_d = rnd_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_q <= '0;
            target_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            sample_q <= sample_d;
            target_q <= target_d;
            valid_q  <= valid_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign target       = target_q;

endmodule

// File: tb/tb_rnd_sample_hold.sv
// Self-checking bench for rnd_sample_hold: per-feature tasks with a queue of expected samples.
module tb_rnd_sample_hold;

    logic        clk;
    logic        reset_n;
    logic [7:0]  rnd_in;
    logic        enable;
    logic [15:0] period;
    logic        mode;
    logic [2:0]  shift;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic [7:0]  target;

    int n_vec;
    int n_err;

    rnd_sample_hold #(
        .WIDTH    (8),
        .DIV_WIDTH(16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rnd_in      (rnd_in),
        .enable      (enable),
        .period      (period),
        .mode        (mode),
        .shift       (shift),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .target      (target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        rnd_in  = 8'hA5;
        mode    = 1'b0;
        shift   = 3'd0;
        period  = 16'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_vec++;
            if (sample_out !== 8'h00) begin
                n_err++;
                $display("FAIL reset_sample cyc%0d: got %h want 00", k, sample_out);
            end
            n_vec++;
            if (sample_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_valid cyc%0d: got %b want 0", k, sample_valid);
            end
            n_vec++;
            if (target !== 8'h00) begin
                n_err++;
                $display("FAIL reset_target cyc%0d: got %h want 00", k, target);
            end
        end
        enable  = 1'b0;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_step_timing();
        logic [7:0] exp_q[$];
        logic [7:0] last;
        logic [7:0] e;
        logic       want_v;
        do_reset();
        mode   = 1'b0;
        period = 16'd3;
        rnd_in = 8'h3C;
        enable = 1'b1;
        last   = 8'h00;
        // Edge 0 is the IDLE->RUN edge; ticks then land on edges 4, 8, 12, ...
        for (int k = 0; k <= 20; k++) begin
            want_v = (k >= 4) && (k % 4 == 0);
            if (want_v) exp_q.push_back(rnd_in);
            step();
            n_vec++;
            if (sample_valid !== want_v) begin
                n_err++;
                $display("FAIL step_valid edge%0d: got %b want %b", k, sample_valid, want_v);
            end
            if (want_v) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_vec++;
                if (sample_out !== e || target !== e) begin
                    n_err++;
                    $display("FAIL step_sample edge%0d: got %h/%h want %h", k, sample_out,
                             target, e);
                end
                last = e;
            end else begin
                n_vec++;
                if (sample_out !== last) begin
                    n_err++;
                    $display("FAIL step_hold edge%0d: got %h want %h", k, sample_out, last);
                end
            end
            rnd_in = (k < 3) ? 8'h3C : 8'($urandom_range(0, 255));
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_slew_up();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        logic       want_v;
        do_reset();
        mode   = 1'b1;
        shift  = 3'd1;
        period = 16'd3;
        rnd_in = 8'h80;
        enable = 1'b1;
        exp_q  = '{8'h00, 8'h40, 8'h60, 8'h70, 8'h78, 8'h7C, 8'h7E, 8'h7F, 8'h7F, 8'h7F};
        for (int k = 0; k <= 13; k++) begin
            want_v = (k >= 4) && (k % 4 == 0);
            step();
            n_vec++;
            if (sample_valid !== want_v) begin
                n_err++;
                $display("FAIL slew_up_valid edge%0d: got %b want %b", k, sample_valid, want_v);
            end
            if (k == 4) begin
                n_vec++;
                if (target !== 8'h80) begin
                    n_err++;
                    $display("FAIL slew_up_target: got %h want 80", target);
                end
            end
            if (k >= 4) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_vec++;
                if (sample_out !== e) begin
                    n_err++;
                    $display("FAIL slew_up_seq edge%0d: got %h want %h", k, sample_out, e);
                end
            end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_slew_down();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        logic [7:0] prev;
        do_reset();
        mode   = 1'b0;
        shift  = 3'd2;
        period = 16'd0;
        rnd_in = 8'hFF;
        enable = 1'b1;
        step();
        step();
        // Tick in slew mode: target takes 00 while sample_out still slews toward the old FF.
        mode   = 1'b1;
        rnd_in = 8'h00;
        step();
        n_vec++;
        if (sample_out !== 8'hFF || target !== 8'h00 || sample_valid !== 1'b1) begin
            n_err++;
            $display("FAIL slew_down_setup: got %h/%h/%b want ff/00/1", sample_out, target,
                     sample_valid);
        end
        period = 16'd200;
        exp_q  = '{8'hBF, 8'h8F, 8'h6B, 8'h50, 8'h3C, 8'h2D, 8'h21, 8'h18, 8'h12,
                   8'h0D, 8'h09, 8'h06, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00};
        prev   = 8'hFF;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            n_vec++;
            if (sample_out !== e || sample_out > prev) begin
                n_err++;
                $display("FAIL slew_down_seq: got %h want %h (prev %h)", sample_out, e, prev);
            end
            prev = sample_out;
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_period_shrink();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        logic       want_v;
        do_reset();
        mode   = 1'b0;
        period = 16'd100;
        enable = 1'b1;
        for (int k = 0; k <= 80; k++) begin
            rnd_in = 8'(k) ^ 8'h5A;
            want_v = (k == 51) || (k == 62) || (k == 73);
            if (want_v) exp_q.push_back(rnd_in);
            step();
            n_vec++;
            if (sample_valid !== want_v) begin
                n_err++;
                $display("FAIL shrink_valid edge%0d: got %b want %b", k, sample_valid, want_v);
            end
            if (want_v) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_vec++;
                if (sample_out !== e) begin
                    n_err++;
                    $display("FAIL shrink_sample edge%0d: got %h want %h", k, sample_out, e);
                end
            end
            // cnt reaches 50 on edge 50; shrinking now forces a tick on edge 51.
            if (k == 50) period = 16'd10;
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_enable_drop();
        logic [7:0] exp_q[$];
        logic [7:0] e;
        logic       want_v;
        do_reset();
        mode   = 1'b0;
        period = 16'd2;
        enable = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            if (k == 6) begin
                enable = 1'b0;
                rnd_in = 8'h77;
            end else begin
                rnd_in = 8'h10 + 8'(k);
            end
            want_v = (k == 3) || (k == 6);
            if (want_v) exp_q.push_back(rnd_in);
            step();
            n_vec++;
            if (sample_valid !== want_v) begin
                n_err++;
                $display("FAIL drop_valid edge%0d: got %b want %b", k, sample_valid, want_v);
            end
            if (want_v) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                n_vec++;
                if (sample_out !== e || target !== e) begin
                    n_err++;
                    $display("FAIL drop_sample edge%0d: got %h/%h want %h", k, sample_out,
                             target, e);
                end
            end else if (k > 6) begin
                n_vec++;
                if (sample_out !== 8'h77 || target !== 8'h77) begin
                    n_err++;
                    $display("FAIL drop_hold edge%0d: got %h/%h want 77", k, sample_out, target);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic want_v;
        do_reset();
        mode   = 1'b0;
        period = 16'd2;
        rnd_in = 8'hC3;
        enable = 1'b1;
        repeat (4) step();
        n_vec++;
        if (sample_out !== 8'hC3) begin
            n_err++;
            $display("FAIL areset_pre: got %h want c3", sample_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (sample_out !== 8'h00 || target !== 8'h00 || sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL areset_clear: got %h/%h/%b want 00/00/0", sample_out, target,
                     sample_valid);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        rnd_in  = 8'h5E;
        for (int k = 0; k <= 4; k++) begin
            want_v = (k == 3);
            step();
            n_vec++;
            if (sample_valid !== want_v) begin
                n_err++;
                $display("FAIL areset_restart edge%0d: got %b want %b", k, sample_valid, want_v);
            end
        end
        n_vec++;
        if (target !== 8'h5E) begin
            n_err++;
            $display("FAIL areset_target: got %h want 5e", target);
        end
        enable = 1'b0;
        step();
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        rnd_in  = 8'h00;
        period  = 16'd0;
        mode    = 1'b0;
        shift   = 3'd0;
        test_reset();
        test_step_timing();
        test_slew_up();
        test_slew_down();
        test_period_shrink();
        test_enable_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
